// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit for the RV32M instruction group.
// One shift-add (multiply) or restoring-subtract (divide) step per CALC cycle
// on operand magnitudes; signs are applied when the result is written.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  state_t          state;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] hi_q;    // product high half / partial remainder
  logic [XLEN-1:0] lo_q;    // multiplier being consumed / dividend becoming quotient
  logic [XLEN-1:0] opnd_q;  // multiplicand / divisor magnitude
  logic [5:0]      cnt_q;

  // Request decode: operand signs, magnitudes and the single-cycle special cases
  logic            is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
               (funct3 == F_DIV) || (funct3 == F_REM);
    b_signed = (funct3 == F_MUL) || (funct3 == F_MULH) ||
               (funct3 == F_DIV) || (funct3 == F_REM);
    sa       = a_signed & A[XLEN-1];
    sb       = b_signed & B[XLEN-1];
    mag_a    = sa ? (~A + 1'b1) : A;
    mag_b    = sb ? (~B + 1'b1) : B;
    div_zero = is_div && (B == '0);
    div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
               (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) fast_res = funct3[1] ? A : '1;
    else          fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of the shared datapath, plus the signed result it would give
  // if it were the last one
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, hi_n, lo_n, quo_f, rem_f, fix_res;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_f;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // when the trial subtraction succeeds the difference is below the divisor,
    // so the modulo-2^XLEN difference is exact
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (op_q[2]) begin
      hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod    = {hi_n, lo_n};
    prod_f  = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
    quo_f   = (sa_q ^ sb_q) ? (~lo_n + 1'b1) : lo_n;
    rem_f   = sa_q ? (~hi_n + 1'b1) : hi_n;
    case (op_q)
      3'b000:                fix_res = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fix_res = quo_f;
      default:               fix_res = rem_f;
    endcase
  end

  // Control FSM and datapath registers; flush beats start and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            op_q   <= funct3;
            sa_q   <= sa;
            sb_q   <= sb;
            hi_q   <= '0;
            lo_q   <= is_div ? mag_a : mag_b;
            opnd_q <= is_div ? mag_b : mag_a;
            cnt_q  <= '0;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fast_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(XLEN-1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fix_res;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
